// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: rounding modes, IEEE-754 single constants,
// operand classification and the divider FSM state encoding.
// No ports; imported by the divider and the round/pack stage.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } r_mode_t;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Exponent 0 is treated as zero, so subnormals are flushed here.
    function automatic fp_class_t classify(input logic [31:0] fp);
        fp_class_t c;
        c.is_zero = (fp[30:23] == 8'h00);
        c.is_inf  = (fp[30:23] == EXP_MAX) && (fp[22:0] == 23'd0);
        c.is_nan  = (fp[30:23] == EXP_MAX) && (fp[22:0] != 23'd0);
        return c;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        ROUND,
        DONE
    } div_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round and pack a 27-bit quotient/product into IEEE-754 single.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: sign, exp_in (10-bit two's complement biased exponent), q[26:0]
// (1 integer bit, 23 fraction, norm, guard, round), sticky, r_mode in;
// fp_Z, ovrf, udrf out.
module fp_round_pack
    import fpu_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  exp_in,
    input  logic [26:0] q,
    input  logic        sticky,
    input  logic [2:0]  r_mode,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);

    logic [25:0]        q_n;
    logic signed [9:0]  e_n;
    logic signed [9:0]  e_r;
    logic [22:0]        mant;
    logic [22:0]        mant_f;
    logic [23:0]        sum;
    logic               g;
    logic               s;
    logic               inc;
    logic               ovf_to_inf;

    always_comb begin
        // A quotient below 1.0 has its leading one at bit 25; bring it up.
        if (q[26]) begin
            q_n = q[25:0];
            e_n = $signed(exp_in);
        end else begin
            q_n = {q[24:0], 1'b0};
            e_n = $signed(exp_in) - 10'sd1;
        end

        mant = q_n[25:3];
        g    = q_n[2];
        s    = (|q_n[1:0]) | sticky;

        case (r_mode_t'(r_mode))
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (g | s);
            RUP:     inc = ~sign & (g | s);
            RMM:     inc = g;
            default: inc = g & (s | mant[0]);
        endcase

        sum = {1'b0, mant} + {23'd0, inc};

        // Carry out of the mantissa: 1.111..1 rounds to 10.0, bump exponent.
        if (sum[23]) begin
            e_r    = e_n + 10'sd1;
            mant_f = 23'd0;
        end else begin
            e_r    = e_n;
            mant_f = sum[22:0];
        end

        case (r_mode_t'(r_mode))
            RTZ:     ovf_to_inf = 1'b0;
            RDN:     ovf_to_inf = sign;
            RUP:     ovf_to_inf = ~sign;
            default: ovf_to_inf = 1'b1;
        endcase

        ovrf = 1'b0;
        udrf = 1'b0;
        fp_Z = {sign, e_r[7:0], mant_f};
        if (e_r >= 10'sd255) begin
            ovrf = 1'b1;
            fp_Z = ovf_to_inf ? {sign, EXP_MAX, 23'd0}
                              : {sign, 8'hFE, 23'h7FFFFF};
        end else if (e_r <= 10'sd0) begin
            udrf = 1'b1;
            fp_Z = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single divider, radix-2 restoring, one quotient bit/cycle.
// Latency: 29 cycles normal path, 2 cycles for special operands (accept cycle counted).
// Backpressure: in_ready only while idle; result held until out_ready, unbounded.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with fp_X, fp_Y,
// r_mode; out_valid/out_ready with fp_Z and flags ovrf, udrf, dz, nv.
module fp_div_iter #(
    parameter int EXP_BIAS = 127,
    parameter int QBITS    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        dz,
    output logic        nv
);
    import fpu_pkg::*;

    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

    div_state_t   state;
    logic         sgn;
    logic [2:0]   rmode;
    logic [7:0]   ex;
    logic [7:0]   ey;
    logic [23:0]  my;
    fp_class_t    xc;
    fp_class_t    yc;
    logic [24:0]  rem;
    logic [26:0]  q;
    logic [4:0]   cnt;

    fp_class_t    in_xc;
    fp_class_t    in_yc;
    logic         in_special;
    logic [24:0]  rem_diff;
    logic [9:0]   e_pre;
    logic [31:0]  rp_z;
    logic         rp_ovrf;
    logic         rp_udrf;

    assign in_xc      = classify(fp_X);
    assign in_yc      = classify(fp_Y);
    assign in_special = (|in_xc) | (|in_yc);

    // Remainder always stays below 2*mY, so the 25-bit subtract never wraps
    // when taken and the shifted result still fits.
    assign rem_diff = rem - {1'b0, my};

    // Wrapping 10-bit arithmetic yields the two's complement biased exponent.
    assign e_pre = {2'b00, ex} - {2'b00, ey} + 10'(EXP_BIAS);

    fp_round_pack u_round_pack (
        .sign   (sgn),
        .exp_in (e_pre),
        .q      (q),
        .sticky (rem != 25'd0),
        .r_mode (rmode),
        .fp_Z   (rp_z),
        .ovrf   (rp_ovrf),
        .udrf   (rp_udrf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            fp_Z      <= 32'd0;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
            dz        <= 1'b0;
            nv        <= 1'b0;
            sgn       <= 1'b0;
            rmode     <= 3'd0;
            ex        <= 8'd0;
            ey        <= 8'd0;
            my        <= 24'd0;
            xc        <= '0;
            yc        <= '0;
            rem       <= 25'd0;
            q         <= 27'd0;
            cnt       <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn      <= fp_X[31] ^ fp_Y[31];
                        rmode    <= r_mode;
                        ex       <= fp_X[30:23];
                        ey       <= fp_Y[30:23];
                        my       <= {1'b1, fp_Y[22:0]};
                        xc       <= in_xc;
                        yc       <= in_yc;
                        // The remainder starts out as the dividend mantissa.
                        rem      <= {2'b01, fp_X[22:0]};
                        q        <= 27'd0;
                        cnt      <= 5'd0;
                        ovrf     <= 1'b0;
                        udrf     <= 1'b0;
                        dz       <= 1'b0;
                        nv       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= in_special ? SPECIAL : DIVIDE;
                    end
                end

                SPECIAL: begin
                    if (xc.is_nan || yc.is_nan || (xc.is_zero && yc.is_zero) ||
                        (xc.is_inf && yc.is_inf)) begin
                        fp_Z <= QNAN;
                        nv   <= 1'b1;
                    end else if (yc.is_zero) begin
                        fp_Z <= {sgn, EXP_MAX, 23'd0};
                        dz   <= 1'b1;
                    end else if (xc.is_inf) begin
                        fp_Z <= {sgn, EXP_MAX, 23'd0};
                    end else begin
                        // Zero dividend or infinite divisor.
                        fp_Z <= {sgn, 31'd0};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DIVIDE: begin
                    if (rem >= {1'b0, my}) begin
                        rem <= {rem_diff[23:0], 1'b0};
                        q   <= {q[25:0], 1'b1};
                    end else begin
                        rem <= {rem[23:0], 1'b0};
                        q   <= {q[25:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    fp_Z      <= rp_z;
                    ovrf      <= rp_ovrf;
                    udrf      <= rp_udrf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: reset, rounding, specials, overflow and
// underflow, output backpressure and mid-operation reset.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = 32'd0;
    logic [31:0] fp_Y = 32'd0;
    logic [2:0]  r_mode = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        dz;
    logic        nv;

    int checks = 0;
    int passes = 0;

    fp_div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .dz        (dz),
        .nv        (nv)
    );

    always #5 clk = ~clk;

    // Issues one operation and returns the result. Latency counts the accept
    // cycle as cycle 1. On timeout the outputs are X so later checks fail.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] m, output logic [31:0] z,
                          output logic [3:0] flags, output int lat);
        int k;
        @(negedge clk);
        fp_X      = x;
        fp_Y      = y;
        r_mode    = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (out_valid) begin
            z     = fp_Z;
            flags = {ovrf, udrf, dz, nv};
            lat   = k + 1;
        end else begin
            z     = 'x;
            flags = 'x;
            lat   = -1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
        checks++; if (fp_Z !== 32'd0) $display("FAIL reset_fp_z got %h exp 00000000", fp_Z); else passes++;
        checks++; if ({ovrf, udrf, dz, nv} !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", {ovrf, udrf, dz, nv}); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
        run_op(32'h40C00000, 32'h40000000, 3'b000, z, f, lat);
        checks++; if (z !== 32'h40400000) $display("FAIL normal_z got %h exp 40400000", z); else passes++;
        checks++; if (f !== 4'b0000) $display("FAIL normal_flags got %b exp 0000", f); else passes++;
        checks++; if (lat !== 29) $display("FAIL normal_latency got %0d exp 29", lat); else passes++;
    endtask

    task automatic test_rounding();
        logic [31:0] xs [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000};
        logic [2:0]  ms [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b111, 3'b011};
        logic [31:0] es [6] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h3EAAAAAB, 32'hBEAAAAAA};
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], 32'h40400000, ms[i], z, f, lat);
            checks++; if (z !== es[i]) $display("FAIL round_%0d_z got %h exp %h", i, z, es[i]); else passes++;
            checks++; if (f !== 4'b0000) $display("FAIL round_%0d_flags got %b exp 0000", i, f); else passes++;
        end
    endtask

    task automatic test_special();
        logic [31:0] xs [6] = '{32'h3F800000, 32'h00000000, 32'h00400000, 32'h7F800000, 32'h3F800000, 32'h7FC00001};
        logic [31:0] ys [6] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hC0000000, 32'h7F800000, 32'h3F800000};
        logic [31:0] es [6] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h00000000, 32'h7FC00000};
        logic [3:0]  fs [6] = '{4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], ys[i], 3'b000, z, f, lat);
            checks++; if (z !== es[i]) $display("FAIL special_%0d_z got %h exp %h", i, z, es[i]); else passes++;
            checks++; if (f !== fs[i]) $display("FAIL special_%0d_flags got %b exp %b", i, f, fs[i]); else passes++;
            checks++; if (lat !== 2) $display("FAIL special_%0d_latency got %0d exp 2", i, lat); else passes++;
        end
    endtask

    task automatic test_ovf_udf();
        logic [31:0] xs [5] = '{32'h7F000000, 32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h00800000};
        logic [31:0] ys [5] = '{32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h40000000};
        logic [2:0]  ms [5] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b000};
        logic [31:0] es [5] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 32'h00000000};
        logic [3:0]  fs [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], ys[i], ms[i], z, f, lat);
            checks++; if (z !== es[i]) $display("FAIL range_%0d_z got %h exp %h", i, z, es[i]); else passes++;
            checks++; if (f !== fs[i]) $display("FAIL range_%0d_flags got %b exp %b", i, f, fs[i]); else passes++;
        end
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge clk);
        fp_X      = 32'h40C00000;
        fp_Y      = 32'h40000000;
        r_mode    = 3'b000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %b exp 1", out_valid); else passes++;
        // A competing 1/0 request must be ignored while the result is held.
        for (int i = 0; i < 10; i++) begin
            fp_X     = 32'h3F800000;
            fp_Y     = 32'h00000000;
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, ovrf, udrf, dz, nv, fp_Z} !== {1'b1, 1'b0, 4'b0000, 32'h40400000})
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b flags=%b z=%h exp vld=1 rdy=0 flags=0000 z=40400000",
                         i, out_valid, in_ready, {ovrf, udrf, dz, nv}, fp_Z);
            else passes++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b exp 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b exp 0", out_valid); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_ghost_result got %b exp 0", out_valid); else passes++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
        @(negedge clk);
        fp_X      = 32'h40C00000;
        fp_Y      = 32'h40000000;
        r_mode    = 3'b000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL abort_busy got in_ready=%b exp 0", in_ready); else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b exp 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got %b exp 0", out_valid); else passes++;
        run_op(32'h40C00000, 32'h40000000, 3'b000, z, f, lat);
        checks++; if (z !== 32'h40400000) $display("FAIL abort_rerun_z got %h exp 40400000", z); else passes++;
        checks++; if (lat !== 29) $display("FAIL abort_rerun_latency got %0d exp 29", lat); else passes++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_special();
        test_ovf_udf();
        test_backpressure();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, %0d/%0d passed so far", passes, checks);
        $fatal(1);
    end

endmodule
